// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-memory port, hazard/redirect
// inputs and the IF/ID pipeline register outputs of the fetch stage.
// The master modport is the fetch stage; the slave modport is its surroundings
// (instruction memory, hazard unit, branch resolution and the ID stage).
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic        halted;

  modport master (
    output imem_addr,
    output imem_en,
    output if_id_ir,
    output if_id_npc,
    output if_id_valid,
    output halted,
    input  imem_rdata,
    input  stall,
    input  branch_taken,
    input  branch_target
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    input  if_id_ir,
    input  if_id_npc,
    input  if_id_valid,
    input  halted,
    output imem_rdata,
    output stall,
    output branch_taken,
    output branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage of the 32-bit MIPS pipeline.
// Holds the PC, drives the instruction-memory address and captures the
// fetched word plus its pc+4 into the IF/ID register. Priority per edge:
// rst, branch redirect (flushes IF/ID), stall (holds everything), fetch.
// Optional feature macro: INSTR_FETCH_HALT_DETECT_EN
//   defined   - a fetched HALT (opcode 6'b111111) moves the stage to HALTED,
//               where PC holds and bubbles are issued until rst or a branch.
//   undefined - HALT words are fetched like any other instruction and
//               halted is tied low.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_e;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] npc_q;
  logic        valid_q;

  // Sequential increment wraps silently at the top of the address space.
  logic [31:0] pc_plus4;
  // Redirect address is always word aligned; the low two bits are dropped.
  logic [31:0] redirect_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = bus.branch_target & 32'hFFFF_FFFC;

`ifdef INSTR_FETCH_HALT_DETECT_EN
  logic is_halt;
  assign is_halt = (bus.imem_rdata[31:26] == HALT_OPCODE);
`endif

  // Single-process FSM: PC, state and IF/ID register all update here.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= S_FETCH;
      ir_q    <= 32'h0;
      npc_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect wins over stall and cancels a wrong-path HALT.
      pc_q    <= redirect_pc;
      state_q <= S_FETCH;
      ir_q    <= 32'h0;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= bus.imem_rdata;
          npc_q   <= pc_plus4;
          valid_q <= 1'b1;
          pc_q    <= pc_plus4;
`ifdef INSTR_FETCH_HALT_DETECT_EN
          // The HALT itself is latched as valid so it drains downstream once.
          if (is_halt) begin
            state_q <= S_HALTED;
          end
`endif
        end
        S_HALTED: begin
          ir_q    <= 32'h0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_ir    = ir_q;
  assign bus.if_id_npc   = npc_q;
  assign bus.if_id_valid = valid_q;
  // Without halt detection the state never leaves FETCH, so this reduces
  // to !stall in that build.
  assign bus.imem_en     = (state_q == S_FETCH) && !bus.stall;

`ifdef INSTR_FETCH_HALT_DETECT_EN
  assign bus.halted = (state_q == S_HALTED);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction-fetch (IF) stage of the 32-bit MIPS pipeline, sitting directly upstream of the ID-stage decode/control unit.
- Holds the program counter and drives the instruction-memory address.
- Captures the fetched word into the IF/ID pipeline register together with its next-PC.
- Handles pipeline stall, branch/jump redirect with flush, and stops fetching once a HALT instruction (opcode 6'b111111) has been fetched.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address of the word being fetched; equals pc.
- imem_en  output  1  fetch enable; 1 when state is FETCH and stall is 0.
- imem_rdata  input  32  instruction word at imem_addr, valid combinationally in the same cycle.
- stall  input  1  from hazard unit; hold pc and IF/ID contents.
- branch_taken  input  1  redirect request from a later stage.
- branch_target  input  32  redirect address; bits [1:0] are ignored and forced to 0.
- if_id_ir  output  32  registered instruction for ID.
- if_id_npc  output  32  registered pc+4 of that instruction.
- if_id_valid  output  1  if_id_ir holds a real instruction; 0 means bubble.
- halted  output  1  state is HALTED.

## Operation
- Internal state: pc[31:0], plus a 2-state FSM with states FETCH and HALTED.
- Per-edge priority, highest first: rst, branch_taken, stall, state action.
- rst:
  - pc <= RESET_PC; state <= FETCH.
  - if_id_ir <= 0, if_id_npc <= 0, if_id_valid <= 0.
- branch_taken (in any state, and regardless of stall):
  - pc <= {branch_target[31:2], 2'b00}.
  - if_id_ir <= 0, if_id_valid <= 0 (flushes the wrong-path instruction).
  - state <= FETCH, so a wrong-path HALT is cancelled.
- stall (with no branch): pc, IF/ID and state are all held unchanged.
- FETCH, normal:
  - if_id_ir <= imem_rdata; if_id_npc <= pc+4; if_id_valid <= 1; pc <= pc+4.
  - If imem_rdata[31:26] == 6'b111111, the HALT itself is still latched as valid, and state <= HALTED.
- HALTED:
  - pc is held.
  - if_id_ir <= 0 and if_id_valid <= 0 every cycle (bubbles), so the HALT drains downstream exactly once.
- Exit paths from HALTED: only rst or branch_taken.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.

## Timing
- Fetch-to-IF/ID latency: 1 cycle. The word at pc in cycle n appears on if_id_ir after edge n.
- Redirect latency: 1 cycle. The target address is on imem_addr in the cycle after branch_taken is sampled.
- Output values during and after reset:
  - imem_addr = RESET_PC, imem_en = 1, halted = 0.
  - if_id_ir = 0, if_id_npc = 0, if_id_valid = 0.
- halted rises on the edge that latches the HALT into IF/ID.
- imem_en is combinational from state and stall.
- Boundary cases:
  - stall with branch_taken in the same cycle: the branch wins.
  - rst with branch_taken in the same cycle: rst wins.
  - HALT fetched while stall is 1: not acted on until stall drops.
  - rst asserted mid-halt or mid-stall: returns to RESET_PC, state FETCH on the next edge.

## Configuration
- Macro: INSTR_FETCH_HALT_DETECT_EN.
- Defined: HALT detection, the HALTED state and the halted output operate as described above.
- Undefined:
  - The FSM is never left in FETCH, and HALT words are fetched like any other instruction with pc advancing.
  - halted is tied to 0.
  - imem_en = !stall.

## Test plan
- Reset release with RESET_PC=0, memory words 0x20010005 then 0x20020007: if_id_ir sequence 0x20010005 then 0x20020007, if_id_npc 4 then 8, valid=1 from the first edge after reset.
- stall held 3 cycles at pc=8: imem_addr stays 8, and if_id_ir/if_id_npc/if_id_valid are unchanged for all 3 cycles.
- branch_taken with branch_target=0x43 at pc=0x10, stall=1 in the same cycle:
  - next cycle imem_addr=0x40, if_id_valid=0, if_id_ir=0.
  - following cycle the word at 0x40 is valid.
- HALT 0xFC000000 at address 0xC:
  - it appears once on if_id_ir with valid=1, halted=1, pc held at 0x10.
  - all later cycles show bubbles until branch_taken to 0x0 resumes fetching with halted=0.
- Wrap: RESET_PC=32'hFFFF_FFFC → after the first fetch, if_id_npc=0 and imem_addr=0.
- rst pulsed while HALTED: next cycle imem_addr=RESET_PC, halted=0, if_id_valid=0.
